vm_input_conditioner: RTL and testbench

Front-end input stage for the vending machine: synchronises the four push-buttons and four slide switches onto the divided clock domain, debounces each button with a per-button state machine, and emits single-cycle command pulses plus a coin value and selection captured on the same cycle. It sits directly upstream of `vending_machine_core`, replacing the bare two-flop/edge-detect logic, and drives that core's `coin_insert`, `cancel`, `rst`, `coin_value` and `selection` inputs.

---
 rtl/vm_input_conditioner.sv | 221 ++++++++++++++++++++++
 tb/tb_vm_input_conditioner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_input_conditioner.sv
// vm_input_conditioner
//
// Front-end input stage for the vending machine, clocked on the divided clock.
// Synchronises the raw push-buttons and slide switches, debounces each button
// with its own four-state machine and produces single-cycle command pulses for
// the downstream vending_machine_core.
//
// Optional feature macro: VM_INPUT_LOCKOUT_EN
//   defined   - at most one command pulse per cycle, priority
//               reset_req > cancel > coin_insert; while any of btn[2:0] is
//               debounced-high, new presses of the other command buttons are
//               accepted (btn_stable rises) but never pulse.
//   undefined - all buttons are independent; simultaneous pulses allowed.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronised samples needed beyond the first one
//                     to accept a press or release (1..65535)
//   CNT_W           - debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk         in   divided system clock
//   rst         in   asynchronous active-high reset
//   btn[3:0]    in   raw buttons: [0] coin, [1] cancel, [2] machine reset,
//                    [3] reserved (debounced level only)
//   sw[3:0]     in   raw switches: [1:0] coin value, [3:2] selection
//   coin_insert out  one-cycle pulse on accepted press of btn[0]
//   cancel      out  one-cycle pulse on accepted press of btn[1]
//   reset_req   out  one-cycle pulse on accepted press of btn[2]
//   coin_value  out  sw[1:0] captured together with coin_insert, held otherwise
//   selection   out  synchronised sw[3:2], follows every cycle
//   btn_stable  out  debounced level of each button

module vm_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] sw,
  output logic       coin_insert,
  output logic       cancel,
  output logic       reset_req,
  output logic [1:0] coin_value,
  output logic [1:0] selection,
  output logic [3:0] btn_stable
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } btn_state_e;

  localparam logic [CNT_W-1:0] CntTarget = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers
  // ---------------------------------------------------------------------------
  logic [3:0] btn_meta_q;
  logic [3:0] btn_s;
  logic [3:0] sw_meta_q;
  logic [3:0] sw_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= '0;
      btn_s      <= '0;
      sw_meta_q  <= '0;
      sw_s       <= '0;
    end else begin
      btn_meta_q <= btn;
      btn_s      <= btn_meta_q;
      sw_meta_q  <= sw;
      sw_s       <= sw_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce FSMs
  // ---------------------------------------------------------------------------
  btn_state_e       state_q [4];
  btn_state_e       state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];

  // hold_entry[i]: button i completes PRESS_WAIT -> HELD on the coming edge.
  logic [3:0] hold_entry;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      hold_entry[i] = 1'b0;

      case (state_q[i])
        StIdle: begin
          if (btn_s[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = CntOne;
          end
        end

        StPressWait: begin
          if (!btn_s[i]) begin
            state_d[i] = StIdle;
          end else if (cnt_q[i] == CntTarget) begin
            state_d[i]    = StHeld;
            hold_entry[i] = 1'b1;
          end else begin
            // Compare happens before increment, so the counter never exceeds
            // the target and cannot wrap.
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end

        StHeld: begin
          if (!btn_s[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = CntOne;
          end
        end

        StReleaseWait: begin
          if (btn_s[i]) begin
            // Bounce during release: back to HELD without a new pulse.
            state_d[i] = StHeld;
          end else if (cnt_q[i] == CntTarget) begin
            state_d[i] = StIdle;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end

        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      btn_stable[i] = (state_q[i] == StHeld) || (state_q[i] == StReleaseWait);
    end
  end

  // The reserved button only reports its debounced level.
  logic unused_hold_entry;
  assign unused_hold_entry = hold_entry[3];

  // ---------------------------------------------------------------------------
  // Command pulse arbitration
  // ---------------------------------------------------------------------------
  logic [2:0] fire;

`ifdef VM_INPUT_LOCKOUT_EN
  // A button already debounced-high locks out the other command buttons; on
  // simultaneous acceptance the higher-priority button wins and the rest are
  // dropped (they still enter HELD).
  always_comb begin
    fire = '0;
    if (hold_entry[2] && !(btn_stable[0] || btn_stable[1])) begin
      fire[2] = 1'b1;
    end
    if (hold_entry[1] && !hold_entry[2] && !(btn_stable[0] || btn_stable[2])) begin
      fire[1] = 1'b1;
    end
    if (hold_entry[0] && !hold_entry[2] && !hold_entry[1] &&
        !(btn_stable[1] || btn_stable[2])) begin
      fire[0] = 1'b1;
    end
  end
`else
  assign fire = hold_entry[2:0];
`endif

  // ---------------------------------------------------------------------------
  // Registered pulses and coin value capture
  // ---------------------------------------------------------------------------
  logic [2:0] pulse_q;
  logic [1:0] coin_value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q      <= '0;
      coin_value_q <= '0;
    end else begin
      pulse_q <= fire;
      // Loaded on the same edge that raises coin_insert so both are valid
      // together.
      if (fire[0]) begin
        coin_value_q <= sw_s[1:0];
      end
    end
  end

  assign coin_insert = pulse_q[0];
  assign cancel      = pulse_q[1];
  assign reset_req   = pulse_q[2];
  assign coin_value  = coin_value_q;
  assign selection   = sw_s[3:2];

endmodule

// File: tb/tb_vm_input_conditioner.sv
module tb_vm_input_conditioner;

  localparam int unsigned D = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] sw;
  logic       coin_insert;
  logic       cancel;
  logic       reset_req;
  logic [1:0] coin_value;
  logic [1:0] selection;
  logic [3:0] btn_stable;

  vm_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .sw         (sw),
    .coin_insert(coin_insert),
    .cancel     (cancel),
    .reset_req  (reset_req),
    .coin_value (coin_value),
    .selection  (selection),
    .btn_stable (btn_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: synchroniser delay line plus a run-length debouncer.
  // A button's debounced level flips once D+1 consecutive synchronised samples
  // disagree with it; a 0->1 flip on a command button is a pulse.
  logic [3:0] m_meta, m_s, m_sw_meta, m_sw_s, m_lvl;
  int         m_run [4];
  logic [2:0] m_pulse;
  logic [1:0] m_coin;

  task automatic model_reset();
    m_meta = '0; m_s = '0; m_sw_meta = '0; m_sw_s = '0; m_lvl = '0;
    m_pulse = '0; m_coin = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] prev_lvl;
    logic [3:0] rises;
    logic [2:0] p;
    if (rst) begin
      model_reset();
      return;
    end
    prev_lvl = m_lvl;
    rises    = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_s[i] != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == int'(D) + 1) begin
        m_lvl[i] = ~m_lvl[i];
        m_run[i] = 0;
        if (m_lvl[i]) rises[i] = 1'b1;
      end
    end
`ifdef VM_INPUT_LOCKOUT_EN
    p = '0;
    for (int i = 2; i >= 0; i--) begin
      if (rises[i]) begin
        if ((prev_lvl[2:0] & ~(3'b001 << i)) == 3'b000) p[i] = 1'b1;
        break;
      end
    end
`else
    p = rises[2:0];
`endif
    if (p[0]) m_coin = m_sw_s[1:0];
    m_pulse   = p;
    m_s       = m_meta;
    m_meta    = btn;
    m_sw_s    = m_sw_meta;
    m_sw_meta = sw;
  endtask

  task automatic check_outputs();
    check("coin_insert", coin_insert, m_pulse[0]);
    check("cancel", cancel, m_pulse[1]);
    check("reset_req", reset_req, m_pulse[2]);
    check("coin_value", coin_value, m_coin);
    check("selection", selection, m_sw_s[3:2]);
    check("btn_stable", btn_stable, m_lvl);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {coin_insert, cancel, reset_req, coin_value, btn_stable}, 32'h0);
  endtask

  // Inputs change only at negedge; the model follows the DUT edge by edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  int lat;
  int n_coin, n_cancel, n_both;
  bit seen_stable, fell;
  int hold [4];

  initial begin
    rst = 1'b0;
    btn = '0;
    sw  = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_zero("reset_state");
    steps(2);
    rst = 1'b0;
    steps(2);

    // Steady press of coin with sw = 0010.
    sw  = 4'b0010;
    btn = 4'b0001;
    for (lat = 1; lat <= 40; lat++) begin
      step();
      if (coin_insert) break;
    end
    check("press_latency", lat, D + 3);
    check("press_coin_value", coin_value, 2'b10);
    check("press_stable", btn_stable[0], 1'b1);
    step();
    check("press_pulse_width", coin_insert, 1'b0);
    steps(5);
    btn = '0;
    steps(10);

    // Cancel bounces 1,0,1,0 then stays high.
    n_cancel = 0;
    for (int k = 0; k < 4; k++) begin
      btn = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      step();
      if (cancel) n_cancel++;
    end
    check("bounce_no_pulse", n_cancel, 0);
    btn = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      step();
      if (cancel) n_cancel++;
    end
    check("bounce_one_pulse", n_cancel, 1);
    btn = '0;
    steps(10);

    // Short press of 3 cycles is rejected.
    n_coin = 0;
    seen_stable = 1'b0;
    btn = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) btn = '0;
      step();
      if (coin_insert) n_coin++;
      if (btn_stable[0]) seen_stable = 1'b1;
    end
    check("short_press_pulses", n_coin, 0);
    check("short_press_stable", seen_stable, 1'b0);

    // Press, hold, 2-cycle drop, high again: one pulse, stable never falls.
    n_coin = 0;
    seen_stable = 1'b0;
    fell = 1'b0;
    btn = 4'b0001;
    for (int k = 0; k < 22; k++) begin
      if (k == 12) btn = '0;
      if (k == 14) btn = 4'b0001;
      step();
      if (coin_insert) n_coin++;
      if (btn_stable[0]) seen_stable = 1'b1;
      else if (seen_stable) fell = 1'b1;
    end
    check("drop_in_held_pulses", n_coin, 1);
    check("drop_in_held_no_fall", fell, 1'b0);
    btn = '0;
    steps(10);

    // Coin and cancel rise on the same edge.
    n_coin = 0; n_cancel = 0; n_both = 0;
    btn = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      step();
      if (coin_insert) n_coin++;
      if (cancel) n_cancel++;
      if (coin_insert && cancel) n_both++;
    end
    check("simul_cancel", n_cancel, 1);
`ifdef VM_INPUT_LOCKOUT_EN
    check("simul_coin", n_coin, 0);
    check("simul_same_cycle", n_both, 0);
`else
    check("simul_coin", n_coin, 1);
    check("simul_same_cycle", n_both, 1);
`endif
    btn = '0;
    steps(10);

    // Reset during PRESS_WAIT of the machine-reset button, button kept held.
    btn = 4'b0100;
    steps(4);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid_debounce");
    step();
    rst = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      step();
      if (reset_req) break;
    end
    check("rst_requalify_latency", lat, D + 3);
    // Reset while the pulse is high drops it immediately.
    #2 rst = 1'b1;
    #1 check("rst_mid_pulse", reset_req, 1'b0);
    step();
    rst = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      step();
      if (reset_req) break;
    end
    check("rst_second_latency", lat, D + 3);
    btn = '0;
    steps(10);

    // Randomised phase: random hold lengths around the debounce threshold.
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 2 * D + 4);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          btn[i]  = ~btn[i];
          hold[i] = $urandom_range(1, 2 * D + 4);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 7) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 check_zero("rand_rst");
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
